instruction_buffer: RTL and testbench

Decoupling FIFO between instruction fetch and warp_scheduler; drives the scheduler's instruction_in / instruction_valid and consumes its instruction_ready.
Holds fetched instructions tagged with warp id, in strict arrival order, with first-word-fall-through output.
Provides almost-full back-pressure to fetch and a whole-buffer flush for branch redirect or kernel teardown.

---
 rtl/instruction_buffer.sv | 108 ++++++++++
 tb/tb_instruction_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_buffer.sv
// FWFT FIFO between instruction fetch and the warp scheduler, with almost-full back-pressure and flush.
// Optional statistics outputs are enabled by defining INSTR_BUF_STATS_EN.
module instruction_buffer #(
    parameter int DEPTH         = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int WARP_ID_WIDTH = 6,
    parameter int AF_THRESH     = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    fetch_instr,
    input  logic [WARP_ID_WIDTH-1:0] fetch_warp_id,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    output logic                     fetch_almost_full,
    output logic [DATA_WIDTH-1:0]    instr_out,
    output logic [WARP_ID_WIDTH-1:0] instr_warp_id,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
`ifdef INSTR_BUF_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]   stat_hwm,
    output logic [31:0]              stat_push_cnt,
    output logic [31:0]              stat_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + WARP_ID_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;

    assign fetch_ready       = (count != FULL_CNT);
    assign fetch_almost_full = (count >= AF_CNT);
    assign instr_valid       = (count != '0);
    assign push              = fetch_valid && fetch_ready;
    assign pop               = instr_valid && instr_ready;

    assign {instr_out, instr_warp_id} = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) begin
            mem[wr_ptr] <= {fetch_instr, fetch_warp_id};
        end
    end

`ifdef INSTR_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hwm       <= '0;
            stat_push_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (flush) begin
                stat_hwm <= '0;
            end else if (count_next > stat_hwm) begin
                stat_hwm <= count_next;
            end
            if (push && !flush) begin
                stat_push_cnt <= stat_push_cnt + 32'd1;
            end
            if (fetch_valid && !fetch_ready && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_buffer.sv
// Scoreboard bench for instruction_buffer: accepted fetches queue expected entries, a negedge monitor checks pops.
// Statistics checks are compiled only when INSTR_BUF_STATS_EN is defined.
module tb_instruction_buffer;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int WW    = 6;
    localparam int AF    = 12;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] fetch_instr;
    logic [WW-1:0] fetch_warp_id;
    logic          fetch_valid;
    logic          fetch_ready;
    logic          fetch_almost_full;
    logic [DW-1:0] instr_out;
    logic [WW-1:0] instr_warp_id;
    logic          instr_valid;
    logic          instr_ready;
    logic [CW-1:0] count;
`ifdef INSTR_BUF_STATS_EN
    logic [CW-1:0] stat_hwm;
    logic [31:0]   stat_push_cnt;
    logic [31:0]   stat_stall_cnt;
`endif

    instruction_buffer #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .WARP_ID_WIDTH(WW), .AF_THRESH(AF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .fetch_instr(fetch_instr),
        .fetch_warp_id(fetch_warp_id),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_almost_full(fetch_almost_full),
        .instr_out(instr_out),
        .instr_warp_id(instr_warp_id),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .count(count)
`ifdef INSTR_BUF_STATS_EN
        ,
        .stat_hwm(stat_hwm),
        .stat_push_cnt(stat_push_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [WW-1:0] warp;
    } entry_t;

    entry_t exp_q[$];
    entry_t mon_e;
    int     mcount   = 0;
    bit     checking = 1'b0;
    bit     mpush;
    bit     mpop;
    int     total    = 0;
    int     bad      = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 1ns after a rising edge and are consumed by the following one.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input int warp,
                                 input logic rdy, input logic fl);
        fetch_valid   = v;
        fetch_instr   = instr;
        fetch_warp_id = WW'(warp);
        instr_ready   = rdy;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (instr_valid && n < 40) begin
            applyStimulus(1'b0, 32'h0, 0, 1'b1, 1'b0);
            n++;
        end
        checkOutput("drain_done", 64'(instr_valid), 64'(0));
        instr_ready = 1'b0;
    endtask

    // Monitor checks what the DUT presents, then records what the coming edge will accept.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("count", 64'(count), 64'(mcount));
            checkOutput("instr_valid", 64'(instr_valid), 64'(mcount != 0));
            checkOutput("fetch_ready", 64'(fetch_ready), 64'(mcount != DEPTH));
            checkOutput("almost_full", 64'(fetch_almost_full), 64'(mcount >= AF));
            if (rst_n && !flush && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pop", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("pop_instr", 64'(instr_out), 64'(mon_e.instr));
                    checkOutput("pop_warp", 64'(instr_warp_id), 64'(mon_e.warp));
                end
            end
            if (!rst_n || flush) begin
                exp_q.delete();
                mcount = 0;
            end else begin
                mpush = fetch_valid && (mcount != DEPTH);
                mpop  = instr_ready && (mcount != 0);
                if (mpush) exp_q.push_back({fetch_instr, fetch_warp_id});
                mcount = mcount + int'(mpush) - int'(mpop);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_instr = '0; fetch_warp_id = '0;
        instr_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        applyStimulus(1'b0, 32'h0, 0, 1'b0, 1'b0);
        checkOutput("reset_count", 64'(count), 64'(0));
        checkOutput("reset_valid", 64'(instr_valid), 64'(0));
        checkOutput("reset_ready", 64'(fetch_ready), 64'(1));
        checkOutput("reset_af", 64'(fetch_almost_full), 64'(0));
        rst_n = 1'b1;

        $display("[TB] ordered pop of three entries");
        applyStimulus(1'b1, 32'h11, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h33, 3, 1'b0, 1'b0);
        checkOutput("t1_count", 64'(count), 64'(3));
        checkOutput("t1_head", 64'(instr_out), 64'h11);
        checkOutput("t1_head_warp", 64'(instr_warp_id), 64'(1));
        drain();

        $display("[TB] first-word-fall-through latency");
        checkOutput("lat_valid_before", 64'(instr_valid), 64'(0));
        applyStimulus(1'b1, 32'hDEADBEEF, 5, 1'b0, 1'b0);
        checkOutput("lat_valid_after", 64'(instr_valid), 64'(1));
        checkOutput("lat_instr", 64'(instr_out), 64'hDEADBEEF);
        checkOutput("lat_warp", 64'(instr_warp_id), 64'(5));
        drain();

        $display("[TB] fill to full and hold the extra fetch");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h100 + i, i, 1'b0, 1'b0);
            checkOutput("fill_af", 64'(fetch_almost_full), 64'(i + 1 >= 12));
        end
        checkOutput("full_count", 64'(count), 64'(16));
        checkOutput("full_ready", 64'(fetch_ready), 64'(0));
        applyStimulus(1'b1, 32'h1717, 7, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1717, 7, 1'b0, 1'b0);
        checkOutput("held_count", 64'(count), 64'(16));
        applyStimulus(1'b1, 32'h1717, 7, 1'b1, 1'b0);
        checkOutput("pop_while_full", 64'(count), 64'(15));
        applyStimulus(1'b1, 32'h1717, 7, 1'b0, 1'b0);
        checkOutput("held_accepted", 64'(count), 64'(16));
        drain();

        $display("[TB] steady occupancy across pointer wrap");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + i, i, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h300 + i, i + 10, 1'b1, 1'b0);
            checkOutput("steady_count", 64'(count), 64'(5));
        end
        drain();

        $display("[TB] flush with concurrent push and pop");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h400 + i, i, 1'b0, 1'b0);
        checkOutput("pre_flush_count", 64'(count), 64'(7));
        applyStimulus(1'b1, 32'hBAD, 9, 1'b1, 1'b1);
        checkOutput("flush_count", 64'(count), 64'(0));
        checkOutput("flush_valid", 64'(instr_valid), 64'(0));
        checkOutput("flush_ready", 64'(fetch_ready), 64'(1));
        applyStimulus(1'b1, 32'h500, 20, 1'b0, 1'b0);
        checkOutput("post_flush_head", 64'(instr_out), 64'h500);
        applyStimulus(1'b1, 32'h501, 21, 1'b0, 1'b0);
        drain();

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h600 + i, i, 1'b0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h6FF, 1, 1'b1, 1'b0);
        rst_n = 1'b1;
        fetch_valid = 1'b0;
        checkOutput("midrst_count", 64'(count), 64'(0));
        checkOutput("midrst_valid", 64'(instr_valid), 64'(0));
        checkOutput("midrst_ready", 64'(fetch_ready), 64'(1));
        checkOutput("midrst_af", 64'(fetch_almost_full), 64'(0));

`ifdef INSTR_BUF_STATS_EN
        $display("[TB] statistics counters");
        checkOutput("stat_rst_hwm", 64'(stat_hwm), 64'(0));
        checkOutput("stat_rst_push", 64'(stat_push_cnt), 64'(0));
        checkOutput("stat_rst_stall", 64'(stat_stall_cnt), 64'(0));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h700 + i, i, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h800 + i, i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h8FF, 3, 1'b0, 1'b0);
        fetch_valid = 1'b0;
        checkOutput("stat_hwm", 64'(stat_hwm), 64'(16));
        checkOutput("stat_stall", 64'(stat_stall_cnt), 64'(3));
        checkOutput("stat_push", 64'(stat_push_cnt), 64'(26));
        drain();
`endif

        applyStimulus(1'b0, 32'h0, 0, 1'b0, 1'b0);
        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
